seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter PWM_BITS, default 3: width of the brightness PWM counter.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 phase  in  4  one-hot digit select from the ring counter; bit i selects digit i.
REQ-005 load  in  1  one-cycle strobe; capture data_in.
REQ-006 data_in  in  16  four hex nibbles; digit i is data_in[4i+3:4i].
REQ-007 blank_lz  in  1  enables leading-zero blanking.
REQ-008 bright  in  PWM_BITS+1  brightness duty; 0 is off, 2^PWM_BITS or more is full on.
REQ-009 an  out  4  digit anodes, active-low.
REQ-010 seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 upd  out  1  one-cycle pulse when the displayed value changes source.
REQ-012 err  out  1  sticky flag for an illegal phase.

Function
REQ-013 load SHALL write data_in into the pending register and set pend_valid; a later load before a frame start SHALL overwrite the pending value.
REQ-014 Frame start SHALL be the cycle where phase==4'b0001 and the registered previous phase!=4'b0001.
REQ-015 At frame start with pend_valid=1 and load=0, the block SHALL copy pending to shadow, clear pend_valid, and pulse upd on the next cycle.
REQ-016 At frame start with load=1, the block SHALL write data_in directly to shadow, leave pend_valid=0, and pulse upd.
REQ-017 Shadow SHALL change only at frame start, so no frame shows mixed old and new digits.
REQ-018 A free-running PWM_BITS counter pwm SHALL increment every cycle and wrap to 0.
REQ-019 A digit is lit when phase is legal, its phase bit is 1, {1'b0,pwm}<bright, and it is not blanked.
REQ-020 an[i] SHALL be 0 only when digit i is lit.
REQ-021 seg SHALL equal the hex pattern of the selected shadow nibble when a digit is lit, and 7'h7F otherwise.
REQ-022 an and seg SHALL be registered, valid exactly 1 cycle after the phase, pwm and shadow values that produce them.
REQ-023 Blanking applies only when blank_lz=1:
  - digit3 is blanked if nibble3==0.
  - digit k (k=2,1) is blanked if digit k+1 is blanked and nibble k==0.
  - digit0 is never blanked.
REQ-024 Phase legality:
  - phase==0 or more than one bit set is illegal.
  - An illegal phase SHALL force an=4'hF and seg=7'h7F on the next cycle.
  - An illegal phase SHALL set err, which holds until rst.
REQ-025 Hex patterns: 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000, A = 7'b0001000, F = 7'b0001110.

Reset
REQ-026 rst SHALL set the following on the next edge, overriding load and phase:
  - shadow=0, pending=0, pend_valid=0, prev_phase=0, pwm=0
  - an=4'hF, seg=7'h7F, upd=0, err=0
REQ-027 rst asserted mid-frame SHALL discard any pending value.
REQ-028 After rst, the first phase==4'b0001 SHALL count as a frame start.

Structure
REQ-029 A shared package SHALL hold the 16-entry hex-to-segment constant table and the constants SEG_OFF=7'h7F and AN_OFF=4'hF.
REQ-030 Sub-module hex_to_seg7 (4-bit in, 7-bit out, combinational) SHALL perform the decoding.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
  - rst for 2 cycles -> an=F, seg=7F, err=0, upd=0.
  - load 16'h12A0, bright=8, then phase 0001,0010,0100,1000 -> an=E,D,B,7 with seg=1000000,0001000,0100100,1111001, each 1 cycle after its phase.
  - load 16'h0005 mid-frame with blank_lz=1 -> old value until the next 0001 edge; then digits 3..1 an bit held 1 and digit0 shows 5; upd pulses once.
  - load on the same cycle as frame start -> the new value is shown in that frame and pend_valid=0.
  - bright=2, PWM_BITS=3, phase held 0001 -> an[0] low for 2 of every 8 cycles; bright=0 -> an stays F.
  - phase=0011 for one cycle -> an=F next cycle, err=1 held until rst.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and segment table for the multiplexed 4-digit display driver.
package seg_scan_driver_pkg;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DATA_W = DIGITS * NIB_W;

    localparam logic [SEG_W-1:0]  SEG_OFF = 7'h7F;
    localparam logic [DIGITS-1:0] AN_OFF  = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns; entry 15 first, entry 0 last.
    localparam logic [15:0][SEG_W-1:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // A phase is legal only when exactly one bit is set.
    function automatic logic phase_legal(input logic [DIGITS-1:0] p);
        return (p != '0) && ((p & (p - DIGITS'(1))) == '0);
    endfunction

endpackage

// File: rtl/seg_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
    import seg_scan_driver_pkg::*;
(
    input  logic [NIB_W-1:0] hex,
    output logic [SEG_W-1:0] seg_c
);

    // Table lookup of the segment pattern.
    assign seg_c = HEX_SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit scanned display driver with frame-synchronous update, PWM
// brightness, leading-zero blanking and illegal-phase detection.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int unsigned PWM_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     phase,
    input  logic                  load,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  blank_lz,
    input  logic [PWM_BITS:0]     bright,
    output logic [DIGITS-1:0]     an,
    output logic [SEG_W-1:0]      seg,
    output logic                  upd,
    output logic                  err
);

    logic [DIGITS-1:0]   prev_phase;
    logic [DATA_W-1:0]   pending;
    logic                pend_valid;
    logic [DATA_W-1:0]   shadow;
    logic [PWM_BITS-1:0] pwm;

    logic                frame_start_c;
    logic                take_c;
    logic [DATA_W-1:0]   shadow_nxt_c;
    logic [NIB_W-1:0]    nib_c [DIGITS];
    logic [DIGITS-1:0]   blank_c;
    logic [DIGITS-1:0]   lit_c;
    logic [NIB_W-1:0]    sel_nib_c;
    logic [SEG_W-1:0]    dec_seg_c;
    logic                legal_c;
    logic                pwm_on_c;

    // Frame-start detection and choice of the shadow value for this frame.
    // The display path uses the post-update shadow so the first digit of a
    // frame already shows the new value and no frame mixes old and new.
    always_comb begin
        frame_start_c = (phase == 4'b0001) && (prev_phase != 4'b0001);
        take_c        = 1'b0;
        shadow_nxt_c  = shadow;
        if (frame_start_c) begin
            if (load) begin
                shadow_nxt_c = data_in;
                take_c       = 1'b1;
            end else if (pend_valid) begin
                shadow_nxt_c = pending;
                take_c       = 1'b1;
            end
        end
    end

    // Digit nibbles, leading-zero blanking chain, lit mask and nibble select.
    always_comb begin
        sel_nib_c = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib_c[i] = shadow_nxt_c[i*NIB_W +: NIB_W];
        end
        blank_c[3] = blank_lz && (nib_c[3] == 4'd0);
        blank_c[2] = blank_c[3] && (nib_c[2] == 4'd0);
        blank_c[1] = blank_c[2] && (nib_c[1] == 4'd0);
        blank_c[0] = 1'b0;
        legal_c  = phase_legal(phase);
        pwm_on_c = ({1'b0, pwm} < bright);
        lit_c    = (legal_c && pwm_on_c) ? (phase & ~blank_c) : '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (phase[i]) begin
                sel_nib_c = sel_nib_c | nib_c[i];
            end
        end
    end

    hex_to_seg7 u_dec (
        .hex   (sel_nib_c),
        .seg_c (dec_seg_c)
    );

    // Data capture, PWM counter, registered display outputs and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_phase <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
            shadow     <= '0;
            pwm        <= '0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            upd        <= 1'b0;
            err        <= 1'b0;
        end else begin
            prev_phase <= phase;
            pwm        <= pwm + PWM_BITS'(1);
            shadow     <= shadow_nxt_c;
            upd        <= take_c;
            if (load && !frame_start_c) begin
                pending    <= data_in;
                pend_valid <= 1'b1;
            end else if (take_c) begin
                pend_valid <= 1'b0;
            end
            an  <= ~lit_c;
            seg <= (lit_c != '0) ? dec_seg_c : SEG_OFF;
            err <= err | ~legal_c;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: vector table plus directed sequences.
module tb_seg_scan_driver;

    localparam int unsigned PWM_BITS = 3;
    localparam int unsigned NVEC     = 22;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        phase = '0;
    logic              load = 1'b0;
    logic [15:0]       data_in = '0;
    logic              blank_lz = 1'b0;
    logic [PWM_BITS:0] bright = '0;
    logic [3:0]        an;
    logic [6:0]        seg;
    logic              upd;
    logic              err;

    always #5 clk = ~clk;

    seg_scan_driver #(.PWM_BITS(PWM_BITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .phase    (phase),
        .load     (load),
        .data_in  (data_in),
        .blank_lz (blank_lz),
        .bright   (bright),
        .an       (an),
        .seg      (seg),
        .upd      (upd),
        .err      (err)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       upd;
        logic       err;
    } exp_t;

    typedef struct packed {
        logic        rst;
        logic [3:0]  phase;
        logic        load;
        logic [15:0] data;
        logic        blank;
        logic [3:0]  bright;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        upd;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs [NVEC];
    int   n_chk = 0;
    int   n_bad = 0;
    int   m_pwm = 0;
    int   lit_cnt;

    function automatic exp_t mk(input logic [3:0] a, input logic [6:0] s,
                                input logic u, input logic e);
        exp_t x;
        x.an = a; x.seg = s; x.upd = u; x.err = e;
        return x;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        n_chk++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic step(input logic r, input logic [3:0] ph, input logic ld,
                        input logic [15:0] d, input logic bl,
                        input logic [PWM_BITS:0] br, input exp_t e, input string tag);
        exp_t want;
        @(negedge clk);
        rst = r; phase = ph; load = ld; data_in = d; blank_lz = bl; bright = br;
        sb_q.push_back(e);
        @(posedge clk);
        m_pwm = r ? 0 : (m_pwm + 1) % (1 << PWM_BITS);
        #1;
        if (sb_q.size() == 0) begin
            n_chk++; n_bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            want = sb_q.pop_front();
            check({tag, ".an"},  16'(an),  16'(want.an));
            check({tag, ".seg"}, 16'(seg), 16'(want.seg));
            check({tag, ".upd"}, 16'(upd), 16'(want.upd));
            check({tag, ".err"}, 16'(err), 16'(want.err));
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            rst phase   ld data      bl bright an    seg    upd
        vecs[0]  = '{1'b1, 4'b0000, 1'b0, 16'h0000, 1'b0, 4'd8, 4'hF, 7'h7F, 1'b0};
        vecs[1]  = '{1'b1, 4'b0000, 1'b0, 16'h0000, 1'b0, 4'd8, 4'hF, 7'h7F, 1'b0};
        vecs[2]  = '{1'b0, 4'b1000, 1'b1, 16'h12A0, 1'b0, 4'd0, 4'hF, 7'h7F, 1'b0};
        vecs[3]  = '{1'b0, 4'b0001, 1'b0, 16'h0000, 1'b0, 4'd8, 4'hE, 7'h40, 1'b1};
        vecs[4]  = '{1'b0, 4'b0010, 1'b0, 16'h0000, 1'b0, 4'd8, 4'hD, 7'h08, 1'b0};
        vecs[5]  = '{1'b0, 4'b0100, 1'b0, 16'h0000, 1'b0, 4'd8, 4'hB, 7'h24, 1'b0};
        vecs[6]  = '{1'b0, 4'b1000, 1'b0, 16'h0000, 1'b0, 4'd8, 4'h7, 7'h79, 1'b0};
        vecs[7]  = '{1'b0, 4'b0001, 1'b0, 16'h0000, 1'b1, 4'd8, 4'hE, 7'h40, 1'b0};
        vecs[8]  = '{1'b0, 4'b0010, 1'b1, 16'h0005, 1'b1, 4'd8, 4'hD, 7'h08, 1'b0};
        vecs[9]  = '{1'b0, 4'b0100, 1'b0, 16'h0000, 1'b1, 4'd8, 4'hB, 7'h24, 1'b0};
        vecs[10] = '{1'b0, 4'b1000, 1'b0, 16'h0000, 1'b1, 4'd8, 4'h7, 7'h79, 1'b0};
        vecs[11] = '{1'b0, 4'b0001, 1'b0, 16'h0000, 1'b1, 4'd8, 4'hE, 7'h12, 1'b1};
        vecs[12] = '{1'b0, 4'b0010, 1'b0, 16'h0000, 1'b1, 4'd8, 4'hF, 7'h7F, 1'b0};
        vecs[13] = '{1'b0, 4'b0100, 1'b0, 16'h0000, 1'b1, 4'd8, 4'hF, 7'h7F, 1'b0};
        vecs[14] = '{1'b0, 4'b1000, 1'b0, 16'h0000, 1'b1, 4'd8, 4'hF, 7'h7F, 1'b0};
        vecs[15] = '{1'b0, 4'b0001, 1'b0, 16'h0000, 1'b1, 4'd8, 4'hE, 7'h12, 1'b0};
        vecs[16] = '{1'b0, 4'b1000, 1'b0, 16'h0000, 1'b0, 4'd8, 4'h7, 7'h40, 1'b0};
        vecs[17] = '{1'b0, 4'b0001, 1'b1, 16'h8F3A, 1'b0, 4'd8, 4'hE, 7'h08, 1'b1};
        vecs[18] = '{1'b0, 4'b0010, 1'b0, 16'h0000, 1'b0, 4'd8, 4'hD, 7'h30, 1'b0};
        vecs[19] = '{1'b0, 4'b0100, 1'b0, 16'h0000, 1'b0, 4'd8, 4'hB, 7'h0E, 1'b0};
        vecs[20] = '{1'b0, 4'b1000, 1'b0, 16'h0000, 1'b0, 4'd8, 4'h7, 7'h00, 1'b0};
        vecs[21] = '{1'b0, 4'b0001, 1'b0, 16'h0000, 1'b0, 4'd8, 4'hE, 7'h08, 1'b0};

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].phase, vecs[i].load, vecs[i].data,
                 vecs[i].blank, 4'(vecs[i].bright),
                 mk(vecs[i].an, vecs[i].seg, vecs[i].upd, 1'b0),
                 $sformatf("vec%0d", i));
        end

        // PWM duty with digit0 held: lit while the counter is below bright.
        lit_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b0001, 1'b0, 16'h0, 1'b0, 4'd2,
                 (m_pwm < 2) ? mk(4'hE, 7'h08, 1'b0, 1'b0) : mk(4'hF, 7'h7F, 1'b0, 1'b0),
                 $sformatf("pwm2_%0d", i));
            if (an == 4'hE) lit_cnt++;
        end
        check("pwm2_duty", 16'(lit_cnt), 16'd2);

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b0001, 1'b0, 16'h0, 1'b0, 4'd0,
                 mk(4'hF, 7'h7F, 1'b0, 1'b0), $sformatf("pwm0_%0d", i));
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 4'b0001, 1'b0, 16'h0, 1'b0, 4'd15,
                 mk(4'hE, 7'h08, 1'b0, 1'b0), $sformatf("pwm15_%0d", i));
        end

        // Illegal phase: outputs forced off, err sticky until reset.
        step(1'b0, 4'b0011, 1'b0, 16'h0, 1'b0, 4'd15, mk(4'hF, 7'h7F, 1'b0, 1'b1), "illegal");
        step(1'b0, 4'b0001, 1'b0, 16'h0, 1'b0, 4'd15, mk(4'hE, 7'h08, 1'b0, 1'b1), "post_ill0");
        step(1'b0, 4'b0000, 1'b0, 16'h0, 1'b0, 4'd15, mk(4'hF, 7'h7F, 1'b0, 1'b1), "zero_ph");
        // Pending load discarded by reset mid-frame.
        step(1'b0, 4'b0010, 1'b1, 16'h0BCD, 1'b0, 4'd15, mk(4'hD, 7'h30, 1'b0, 1'b1), "ld_pre_rst");
        step(1'b1, 4'b0001, 1'b0, 16'h0, 1'b0, 4'd15, mk(4'hF, 7'h7F, 1'b0, 1'b0), "rst_a");
        step(1'b1, 4'b0001, 1'b0, 16'h0, 1'b0, 4'd15, mk(4'hF, 7'h7F, 1'b0, 1'b0), "rst_b");
        step(1'b0, 4'b1000, 1'b0, 16'h0, 1'b0, 4'd15, mk(4'h7, 7'h40, 1'b0, 1'b0), "post_rst3");
        step(1'b0, 4'b0001, 1'b0, 16'h0, 1'b0, 4'd15, mk(4'hE, 7'h40, 1'b0, 1'b0), "discard");
        // First 0001 after reset is a frame start even with phase held through reset.
        step(1'b1, 4'b0001, 1'b0, 16'h0, 1'b0, 4'd15, mk(4'hF, 7'h7F, 1'b0, 1'b0), "rst_c");
        step(1'b0, 4'b0001, 1'b1, 16'h0007, 1'b0, 4'd15, mk(4'hE, 7'h78, 1'b1, 1'b0), "first_fs");
        step(1'b0, 4'b0001, 1'b0, 16'h0, 1'b0, 4'd15, mk(4'hE, 7'h78, 1'b0, 1'b0), "held_fs");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
